// File: rtl/uart_host_pkg.sv
// -----------------------------------------------------------------------------
// uart_host_pkg
// Shared types and constants for the host-side 8N1 UART transmitter.
//   tx_state_t : frame sequencer states
//   DIV_MIN    : smallest usable clocks-per-bit value
//   DATA_BITS  : payload bits per frame
// -----------------------------------------------------------------------------
package uart_host_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DIV_MIN   = 2;
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock byte FIFO, depth 2^FIFO_AW, first-word-fall-through read port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pointers only)
//   push, wdata   write strobe and byte; ignored while full
//   pop           read strobe; ignored while empty
//   rdata         byte at the head of the queue (valid whenever !empty)
//   full, empty   occupancy flags
//   level         current occupancy, 0 .. 2^FIFO_AW
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // that differ only in the wrap bit mean full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_host_tx.sv
// -----------------------------------------------------------------------------
// uart_host_tx
// Host-side 8N1 UART transmitter feeding picosoc.ser_rx. Bytes enter through a
// valid/ready stream into a FIFO and are sent LSB first; one bit lasts
// max(cfg_div, 2) clocks, sampled at the start of each frame.
// Ports:
//   clk_50m   system clock
//   resetn    asynchronous active-low reset
//   cfg_div   clocks per bit (0 and 1 behave as 2)
//   s_valid   input byte valid
//   s_data    input byte
//   s_ready   FIFO not full
//   tx        registered serial output, idle high
//   busy      frame in progress or bytes queued
//   level     FIFO occupancy
// -----------------------------------------------------------------------------
module uart_host_tx
    import uart_host_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic               clk_50m,
    input  logic               resetn,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   level
);

    localparam logic [DIV_W-1:0] DIV_ONE   = 1;
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_FLOOR) ? DIV_FLOOR : d;
    endfunction

    tx_state_t        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [7:0]       fifo_rdata;
    logic             bit_end;

    uart_sync_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk_50m),
        .rst_n (resetn),
        .push  (s_valid && s_ready),
        .pop   (pop),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign s_ready = !fifo_full;
    assign busy    = (state_q != IDLE) || !fifo_empty;
    assign tx      = tx_q;
    assign bit_end = (baud_q == (div_q - DIV_ONE));

    // State register
    always_ff @(posedge clk_50m or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; pop is asserted on every edge that enters START so the
    // following frame starts without an idle gap.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end && (bit_q == LAST_DATA)) state_d = STOP;
            end
            STOP: begin
                if (bit_end && (bit_q == LAST_STOP)) begin
                    if (!fifo_empty) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output: tx follows the state being entered so the line changes on the
    // same edge as the FSM.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Baud counter, bit counter and shift register. A pop reloads the divider
    // so cfg_div changes only take effect at a frame boundary.
    always_comb begin
        div_d   = div_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (pop) begin
            div_d   = clamp_div(cfg_div);
            baud_d  = '0;
            bit_d   = '0;
            shreg_d = fifo_rdata;
        end else if (state_q != IDLE) begin
            if (bit_end) begin
                baud_d = '0;
                if (state_q == DATA) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = (bit_q == LAST_DATA) ? 3'd0 : (bit_q + 3'd1);
                end else if (state_q == STOP) begin
                    bit_d = bit_q + 3'd1;
                end
            end else begin
                baud_d = baud_q + DIV_ONE;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge resetn) begin
        if (!resetn) begin
            tx_q   <= 1'b1;
            div_q  <= DIV_FLOOR;
            baud_q <= '0;
            bit_q  <= '0;
        end else begin
            tx_q   <= tx_d;
            div_q  <= div_d;
            baud_q <= baud_d;
            bit_q  <= bit_d;
        end
    end

    always_ff @(posedge clk_50m) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_uart_host_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_host_tx
// Two transmitters share clock, reset and configuration: dut_a has one stop
// bit, dut_b has two. The serial line and busy flag of each are recorded once
// per cycle (after each rising edge) and compared with waveforms built from
// the expected byte stream: start bit, eight data bits LSB first, stop bits,
// each lasting max(cfg_div, 2) cycles, frames back to back while bytes remain.
// -----------------------------------------------------------------------------
module tb_uart_host_tx;

    localparam int TMAX = 100000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] cfg_div = 16'd4;
    logic        s_valid_a = 1'b0;
    logic        s_valid_b = 1'b0;
    logic [7:0]  s_data = 8'h00;

    logic        s_ready_a, tx_a, busy_a;
    logic [4:0]  level_a;
    logic        s_ready_b, tx_b, busy_b;
    logic [4:0]  level_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    bit tra [TMAX];
    bit trb [TMAX];
    bit bsa [TMAX];

    logic [7:0] exp_b [$];
    int         exp_d [$];

    uart_host_tx #(.FIFO_AW(4), .STOP_BITS(1), .DIV_W(16)) dut_a (
        .clk_50m (clk),
        .resetn  (resetn),
        .cfg_div (cfg_div),
        .s_valid (s_valid_a),
        .s_data  (s_data),
        .s_ready (s_ready_a),
        .tx      (tx_a),
        .busy    (busy_a),
        .level   (level_a)
    );

    uart_host_tx #(.FIFO_AW(4), .STOP_BITS(2), .DIV_W(16)) dut_b (
        .clk_50m (clk),
        .resetn  (resetn),
        .cfg_div (cfg_div),
        .s_valid (s_valid_b),
        .s_data  (s_data),
        .s_ready (s_ready_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .level   (level_b)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; trace[k] = value after edge k.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < TMAX) begin
            tra[cyc] <= tx_a;
            trb[cyc] <= tx_b;
            bsa[cyc] <= busy_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_div(input int raw);
        return (raw < 2) ? 2 : raw;
    endfunction

    function automatic int stream_len(input int sb);
        int n;
        n = 0;
        foreach (exp_d[i]) n += (9 + sb) * exp_d[i];
        return n;
    endfunction

    function automatic bit tr(input bit b, input int t);
        return b ? trb[t] : tra[t];
    endfunction

    // Called at a falling edge; offers one byte for the next rising edge.
    task automatic push(input bit b, input logic [7:0] d, output bit acc, output int e);
        s_data = d;
        if (b) s_valid_b = 1'b1;
        else   s_valid_a = 1'b1;
        acc = b ? s_ready_b : s_ready_a;
        e = cyc + 1;
        @(negedge clk);
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_all(input bit b, output int e_first);
        bit acc;
        int e;
        e_first = 0;
        for (int i = 0; i < exp_b.size(); i++) begin
            push(b, exp_b[i], acc, e);
            chk($sformatf("accept byte %0d", i), acc, 1);
            if (i == 0) e_first = e;
        end
    endtask

    task automatic check_stream(input bit b, input int t0, input int sb, input string tag);
        int         t;
        int         bad;
        logic [7:0] by;
        bit         want;
        t = t0;
        chk({tag, " line high before start"}, tr(b, t0 - 1), 1);
        for (int f = 0; f < exp_b.size(); f++) begin
            by  = exp_b[f];
            bad = 0;
            for (int k = 0; k < 9 + sb; k++) begin
                want = (k == 0) ? 1'b0 : ((k <= 8) ? by[k-1] : 1'b1);
                for (int c = 0; c < exp_d[f]; c++) begin
                    if (tr(b, t) !== want) bad++;
                    t++;
                end
            end
            chk($sformatf("%s frame%0d wrong cycles", tag, f), bad, 0);
        end
        bad = 0;
        for (int c = 0; c < 4; c++) if (tr(b, t + c) !== 1'b1) bad++;
        chk({tag, " line idle after"}, bad, 0);
    endtask

    initial begin
        int         e, e0, t0, rc, bad, n, raw;
        bit         acc;
        logic [7:0] by;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("reset tx_a", tx_a, 1);
        chk("reset s_ready_a", s_ready_a, 1);
        chk("reset busy_a", busy_a, 0);
        chk("reset level_a", level_a, 0);
        chk("reset tx_b", tx_b, 1);
        chk("reset busy_b", busy_b, 0);

        // Single byte 0xA5 at 4 clocks per bit
        cfg_div = 16'd4;
        exp_b.delete(); exp_d.delete();
        exp_b.push_back(8'hA5); exp_d.push_back(4);
        push(0, 8'hA5, acc, e);
        chk("single accept", acc, 1);
        t0 = e + 1;
        wait_to(t0 + stream_len(1) + 8);
        check_stream(0, t0, 1, "single");
        chk("busy low before push", bsa[e-1], 0);
        chk("busy high at push edge", bsa[e], 1);
        chk("busy high in last stop cycle", bsa[t0+39], 1);
        chk("busy low 40 cycles after start", bsa[t0+40], 0);

        // Divider values 0 and 1 act as 2
        raw = $urandom_range(0, 1);
        cfg_div = 16'(raw);
        exp_b.delete(); exp_d.delete();
        exp_b.push_back(8'h00); exp_d.push_back(model_div(raw));
        push_all(0, e0);
        t0 = e0 + 1;
        wait_to(t0 + stream_len(1) + 8);
        check_stream(0, t0, 1, "clamp");

        // Random bursts at random dividers
        for (int r = 0; r < 4; r++) begin
            n   = $urandom_range(1, 4);
            raw = $urandom_range(0, 10);
            cfg_div = 16'(raw);
            exp_b.delete(); exp_d.delete();
            for (int i = 0; i < n; i++) begin
                exp_b.push_back(8'($urandom));
                exp_d.push_back(model_div(raw));
            end
            push_all(0, e0);
            t0 = e0 + 1;
            wait_to(t0 + stream_len(1) + 8);
            check_stream(0, t0, 1, $sformatf("rand%0d", r));
            chk("rand busy idle", busy_a, 0);
            chk("rand level idle", level_a, 0);
        end

        // Fill the FIFO at 434 clocks per bit
        cfg_div = 16'd434;
        exp_b.delete(); exp_d.delete();
        for (int i = 0; i < 17; i++) begin
            exp_b.push_back(8'(i));
            exp_d.push_back(434);
        end
        push_all(0, e0);
        chk("full level", level_a, 16);
        chk("full s_ready", s_ready_a, 0);
        exp_b.push_back(8'h11); exp_d.push_back(434);
        acc = 1'b0;
        for (int k = 0; k < 6000 && !acc; k++) push(0, 8'h11, acc, e);
        chk("late byte accepted", acc, 1);
        // The pop edge itself still sees a full FIFO, so the push lands one later.
        chk("late byte accept edge", e, e0 + 1 + 4340 + 1);
        t0 = e0 + 1;
        wait_to(t0 + stream_len(1) + 8);
        check_stream(0, t0, 1, "full");

        // Divider change during the first frame's data bits
        cfg_div = 16'd8;
        exp_b.delete(); exp_d.delete();
        exp_b.push_back(8'($urandom)); exp_d.push_back(8);
        exp_b.push_back(8'($urandom)); exp_d.push_back(16);
        push_all(0, e0);
        t0 = e0 + 1;
        wait_to(t0 + 8 * 3);
        cfg_div = 16'd16;
        wait_to(t0 + stream_len(1) + 8);
        check_stream(0, t0, 1, "divchange");

        // Reset during data bit 3
        cfg_div = 16'd4;
        exp_b.delete(); exp_d.delete();
        exp_b.push_back(8'hA5); exp_d.push_back(4);
        exp_b.push_back(8'($urandom)); exp_d.push_back(4);
        exp_b.push_back(8'($urandom)); exp_d.push_back(4);
        push_all(0, e0);
        t0 = e0 + 1;
        wait_to(t0 + 17);
        chk("pre-reset tx low in bit 3", tx_a, 0);
        chk("pre-reset level", level_a, 2);
        #2 resetn = 1'b0;
        #1;
        chk("async reset tx", tx_a, 1);
        chk("async reset level", level_a, 0);
        chk("async reset busy", busy_a, 0);
        chk("async reset s_ready", s_ready_a, 1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        rc = cyc;
        wait_to(rc + 60);
        bad = 0;
        for (int k = 1; k <= 50; k++) if (tra[rc+k] !== 1'b1) bad++;
        chk("post-reset line idle", bad, 0);
        chk("post-reset busy", busy_a, 0);
        chk("post-reset level", level_a, 0);
        by = 8'($urandom);
        exp_b.delete(); exp_d.delete();
        exp_b.push_back(by); exp_d.push_back(4);
        push_all(0, e0);
        t0 = e0 + 1;
        wait_to(t0 + stream_len(1) + 8);
        check_stream(0, t0, 1, "after-reset");

        // Two stop bits
        cfg_div = 16'd4;
        exp_b.delete(); exp_d.delete();
        exp_b.push_back(8'h3C); exp_d.push_back(4);
        exp_b.push_back(8'($urandom)); exp_d.push_back(4);
        push_all(1, e0);
        t0 = e0 + 1;
        wait_to(t0 + stream_len(2) + 8);
        check_stream(1, t0, 2, "stop2");

        n   = $urandom_range(2, 3);
        raw = $urandom_range(0, 6);
        cfg_div = 16'(raw);
        exp_b.delete(); exp_d.delete();
        for (int i = 0; i < n; i++) begin
            exp_b.push_back(8'($urandom));
            exp_d.push_back(model_div(raw));
        end
        push_all(1, e0);
        t0 = e0 + 1;
        wait_to(t0 + stream_len(2) + 8);
        check_stream(1, t0, 2, "stop2-rand");
        chk("stop2 busy idle", busy_b, 0);
        chk("stop2 level idle", level_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
